// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_pkg
//  Purpose  : Shared constants for the timer counter blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package tmr_pkg;

    localparam int TMR_WIDTH = 8;

    localparam logic TMR_DIR_UP   = 1'b0;
    localparam logic TMR_DIR_DOWN = 1'b1;

    localparam logic [TMR_WIDTH-1:0] TMR_CNT_ONES = {TMR_WIDTH{1'b1}};
    localparam logic [TMR_WIDTH-1:0] TMR_CNT_ZERO = {TMR_WIDTH{1'b0}};

endpackage : tmr_pkg
`default_nettype wire

// File: rtl/tmr_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_edge_det
//  Purpose  : Samples a slow pclk-synchronous signal as data and emits a
//             one-cycle pulse on each of its rising edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_edge_det (
    input  logic pclk,
    input  logic preset_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_in;
        end
    end

    // Previous value resets low so the first rise after reset is a valid edge.
    assign rise = sig_in & ~sig_q;

endmodule : tmr_edge_det
`default_nettype wire

// File: rtl/tmr_cnt_core.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_cnt_core
//  Purpose  : Up/down timer counter advanced by rising edges of clk_int,
//             with reload and sticky overflow/underflow flags.
//             Optional macro TMR_AUTO_RELOAD_EN: reload tdr on wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_cnt_core
    import tmr_pkg::*;
#(
    parameter int WIDTH = TMR_WIDTH
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             clk_int,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] tdr,
    input  logic             ovf_clr,
    input  logic             udf_clr,
    output logic [WIDTH-1:0] tcnt,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             tick;
    logic             cnt_ev;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    tmr_edge_det u_edge_det (
        .pclk     (pclk),
        .preset_n (preset_n),
        .sig_in   (clk_int),
        .rise     (tick)
    );

    assign cnt_ev = en & tick & ~load;

    always_comb begin
        tcnt_d  = tcnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (load) begin
            tcnt_d = tdr;
        end else if (cnt_ev) begin
            if (up_down == TMR_DIR_DOWN) begin
                udf_set = (tcnt_q == '0);
                tcnt_d  = tcnt_q - CNT_ONE;
            end else begin
                ovf_set = (tcnt_q == '1);
                tcnt_d  = tcnt_q + CNT_ONE;
            end
`ifdef TMR_AUTO_RELOAD_EN
            if (ovf_set | udf_set) begin
                tcnt_d = tdr;
            end
`endif
        end
        // A set in the same cycle as a clear keeps the flag high.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        udf_d = udf_set | (udf_q & ~udf_clr);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tcnt_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign tcnt = tcnt_q;
    assign ovf  = ovf_q;
    assign udf  = udf_q;

endmodule : tmr_cnt_core
`default_nettype wire

// File: tb/tb_tmr_cnt_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_cnt_core
//  Purpose  : Self-checking bench for tmr_cnt_core against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_cnt_core;
    import tmr_pkg::*;

`ifdef TMR_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic       clk_int = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       up_down = 1'b0;
    logic [7:0] tdr = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       udf_clr = 1'b0;
    logic [7:0] tcnt;
    logic       ovf;
    logic       udf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt  = 0;
    bit m_ovf  = 0;
    bit m_udf  = 0;
    bit m_prev = 0;

    // clk_int generator: pclk divided by 2^(div_sel+1)
    int div_cnt = 0;
    int div_sel = 0;

    always #5 pclk = ~pclk;

    tmr_cnt_core #(.WIDTH(8)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clk_int  (clk_int),
        .en       (en),
        .load     (load),
        .up_down  (up_down),
        .tdr      (tdr),
        .ovf_clr  (ovf_clr),
        .udf_clr  (udf_clr),
        .tcnt     (tcnt),
        .ovf      (ovf),
        .udf      (udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_tcnt"}, {24'd0, tcnt}, m_cnt);
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
        chk({tag, "_udf"}, {31'd0, udf}, {31'd0, m_udf});
    endtask

    // One pclk: predict from current inputs, clock, compare, then move inputs.
    task automatic step(input string tag);
        bit tk, os, us;
        int n_cnt;
        tk    = clk_int && !m_prev;
        n_cnt = m_cnt;
        os    = 0;
        us    = 0;
        if (load) begin
            n_cnt = tdr;
        end else if (en && tk) begin
            if (up_down) begin
                us    = (m_cnt - 1) < 0;
                n_cnt = (m_cnt + 255) % 256;
            end else begin
                os    = (m_cnt + 1) > 255;
                n_cnt = (m_cnt + 1) % 256;
            end
            if (AR && (os || us)) n_cnt = tdr;
        end
        m_prev = clk_int;
        @(posedge pclk);
        #1;
        m_cnt = n_cnt;
        m_ovf = os ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_udf = us ? 1'b1 : (udf_clr ? 1'b0 : m_udf);
        chk_model(tag);
        load    = 1'b0;
        div_cnt = div_cnt + 1;
        clk_int = div_cnt[div_sel];
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_ovf   = 0;
        m_udf   = 0;
        m_prev  = 0;
        div_cnt = 0;
        clk_int = 1'b0;
    endtask

    initial begin
        bit found;
        // Reset state
        #2;
        chk("rst_tcnt", {24'd0, tcnt}, 32'h0);
        chk("rst_ovf", {31'd0, ovf}, 32'h0);
        chk("rst_udf", {31'd0, udf}, 32'h0);
        @(posedge pclk);
        #1;
        preset_n = 1'b1;

        // Up count at pclk/2 for 10 pclk
        en = 1'b1; up_down = TMR_DIR_UP; div_sel = 0;
        for (int i = 0; i < 10; i++) step("up2");
        chk("up2_final", {24'd0, tcnt}, 32'h5);

        // Load FE, up at pclk/4, wrap sets ovf
        tdr = 8'hFE; load = 1'b1; div_sel = 1;
        step("ldFE");
        for (int i = 0; i < 12; i++) step("up4");
        chk("ovf_sticky", {31'd0, ovf}, 32'h1);
        ovf_clr = 1'b1; step("ovfclr"); ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'h0);

        // Load 01, down at pclk/16, underflow
        tdr = 8'h01; load = 1'b1; up_down = TMR_DIR_DOWN; div_sel = 3;
        step("ld01");
        for (int i = 0; i < 40; i++) step("dn16");
        chk("udf_sticky", {31'd0, udf}, 32'h1);
        udf_clr = 1'b1; step("udfclr"); udf_clr = 1'b0;

        // Wrap with ovf_clr held: set wins, then clear takes effect
        tdr = TMR_CNT_ONES; load = 1'b1; up_down = TMR_DIR_UP; div_sel = 0;
        step("ldFF");
        ovf_clr = 1'b1;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            step("wrapclr");
            found = m_ovf;
        end
        chk("wrapclr_found", {31'd0, found}, 32'h1);
        chk("wrapclr_ovf", {31'd0, ovf}, 32'h1);
        step("wrapclr2");
        chk("wrapclr2_ovf", {31'd0, ovf}, 32'h0);
        ovf_clr = 1'b0;

        // Load coinciding with a tick drops the tick
        div_sel = 1;
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (clk_int && !m_prev) found = 1;
            else step("seek");
        end
        chk("tick_found", {31'd0, found}, 32'h1);
        tdr = 8'h40; load = 1'b1;
        step("ldtick");
        chk("ldtick_val", {24'd0, tcnt}, 32'h40);
        en = 1'b0;
        for (int i = 0; i < 20; i++) step("hold");
        chk("hold_val", {24'd0, tcnt}, 32'h40);

        // Asynchronous reset mid-count with ovf set
        en = 1'b1; div_sel = 0; tdr = TMR_CNT_ONES; load = 1'b1;
        step("ldFF2");
        for (int i = 0; i < 6 && !m_ovf; i++) step("toovf");
        tdr = 8'h33; load = 1'b1; en = 1'b0;
        step("ld33");
        chk("pre_rst_ovf", {31'd0, ovf}, 32'h1);
        #2 preset_n = 1'b0;
        #1;
        chk("arst_tcnt", {24'd0, tcnt}, 32'h0);
        chk("arst_ovf", {31'd0, ovf}, 32'h0);
        chk("arst_udf", {31'd0, udf}, 32'h0);
        model_reset();
        #2 preset_n = 1'b1;

`ifdef TMR_AUTO_RELOAD_EN
        en = 1'b1; up_down = TMR_DIR_UP; tdr = TMR_CNT_ONES; load = 1'b1;
        step("arFF");
        tdr = 8'h80;
        for (int i = 0; i < 6 && !m_ovf; i++) step("arwrap");
        chk("ar_tcnt", {24'd0, tcnt}, 32'h80);
        chk("ar_ovf", {31'd0, ovf}, 32'h1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom % 8) != 0;
            up_down = $urandom % 2;
            load    = ($urandom % 16) == 0;
            tdr     = 8'($urandom);
            ovf_clr = ($urandom % 8) == 0;
            udf_clr = ($urandom % 8) == 0;
            if (($urandom % 60) == 0) div_sel = $urandom % 4;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_tmr_cnt_core
`default_nettype wire
